// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid mine game datapath.
package grid_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_WIN  = 2'd2,
    GS_LOSE = 2'd3
  } game_state_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 3;

  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Movement tick divider: down-counter that pulses at zero while running and
// sits at its reload value otherwise.
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = RELOAD;
    if (clr || !run) begin
      count_d = RELOAD;
    end else if (count_q == {CW{1'b0}}) begin
      count_d = RELOAD;
    end else begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = run && (count_q == {CW{1'b0}});

endmodule

// File: rtl/grid_game_datapath.sv
// Grid mine game datapath: board maps, cursor movement on a divided tick,
// edge-detected flag/step requests and the IDLE/PLAY/WIN/LOSE sequencer.
module grid_game_datapath
  import grid_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 12_500_000,
  parameter int WRAP     = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [ROWS*COLS-1:0]    mine_in,
  input  logic [3:0]              dir,
  input  logic                    flag_req,
  input  logic                    step_req,
  output logic [ROWS*COLS-1:0]    mine_map,
  output logic [ROWS*COLS-1:0]    flag_map,
  output logic [ROWS*COLS-1:0]    step_map,
  output logic [ROWS*COLS-1:0]    pos_map,
  output logic [$clog2(ROWS)-1:0] pos_row,
  output logic [$clog2(COLS)-1:0] pos_col,
  output logic [3:0]              adj_count,
  output logic [1:0]              game_state,
  output logic                    win,
  output logic                    lose
);

  localparam int            N       = ROWS * COLS;
  localparam int            RW      = $clog2(ROWS);
  localparam int            CW      = $clog2(COLS);
  localparam int            IW      = $clog2(N);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [N-1:0]  POS0    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [3:0]    OH_UP   = 4'b0001 << DIR_UP;
  localparam logic [3:0]    OH_RT   = 4'b0001 << DIR_RIGHT;
  localparam logic [3:0]    OH_DN   = 4'b0001 << DIR_DOWN;
  localparam logic [3:0]    OH_LT   = 4'b0001 << DIR_LEFT;

  game_state_t   state_q, state_d;
  logic [N-1:0]  mine_q, mine_d;
  logic [N-1:0]  flag_q, flag_d;
  logic [N-1:0]  step_q, step_d;
  logic [N-1:0]  pos_map_q, pos_map_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    adj_q, adj_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          flag_prev_q, flag_prev_d;
  logic          step_prev_q, step_prev_d;

  logic          tick_s;
  logic          run_s;
  logic          load_go_s;
  logic          flag_rise_s;
  logic          step_rise_s;
  logic [IW-1:0] idx_s;
  logic [IW-1:0] new_idx_s;

  // Mines in the eight in-board neighbours; neighbours never wrap.
  function automatic logic [3:0] adj_popcount(input logic [N-1:0]  mines,
                                              input logic [RW-1:0] row,
                                              input logic [CW-1:0] col);
    logic [3:0]    cnt;
    logic [IW-1:0] k;
    int            dr;
    int            dc;
    cnt = 4'd0;
    for (int i = 0; i < N; i++) begin
      dr = (i / COLS) - int'(row);
      dc = (i % COLS) - int'(col);
      k  = IW'(i);
      if ((dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1) && !((dr == 0) && (dc == 0))) begin
        cnt = cnt + {3'b000, mines[k]};
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  assign run_s       = (state_q == GS_PLAY);
  assign load_go_s   = load && (state_q != GS_PLAY);
  assign flag_rise_s = flag_req && !flag_prev_q;
  assign step_rise_s = step_req && !step_prev_q;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .resetn(resetn),
    .run   (run_s),
    .clr   (load_go_s),
    .tick  (tick_s)
  );

  always_comb begin
    state_d = state_q;
    mine_d  = mine_q;
    flag_d  = flag_q;
    step_d  = step_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_s   = IW'(cell_idx(int'(row_q), int'(col_q), COLS));
    case (state_q)
      GS_PLAY: begin
        if ((mine_q & step_q) != {N{1'b0}}) begin
          state_d = GS_LOSE;
        end else if ((flag_q == mine_q) && (mine_q != {N{1'b0}})) begin
          state_d = GS_WIN;
        end else begin
          state_d = GS_PLAY;
        end
        // Flag beats a same-cycle step; requests use the pre-move cursor.
        if (flag_rise_s) begin
          if (!step_q[idx_s]) begin
            flag_d[idx_s] = ~flag_q[idx_s];
          end else begin
            flag_d = flag_q;
          end
        end else if (step_rise_s && !flag_q[idx_s]) begin
          step_d[idx_s] = 1'b1;
        end else begin
          step_d = step_q;
        end
        if (tick_s) begin
          case (dir)
            OH_UP: row_d = (row_q == {RW{1'b0}}) ? ((WRAP != 0) ? ROW_MAX : {RW{1'b0}})
                                                 : (row_q - RW'(1));
            OH_DN: row_d = (row_q == ROW_MAX) ? ((WRAP != 0) ? {RW{1'b0}} : ROW_MAX)
                                              : (row_q + RW'(1));
            OH_LT: col_d = (col_q == {CW{1'b0}}) ? ((WRAP != 0) ? COL_MAX : {CW{1'b0}})
                                                 : (col_q - CW'(1));
            OH_RT: col_d = (col_q == COL_MAX) ? ((WRAP != 0) ? {CW{1'b0}} : COL_MAX)
                                              : (col_q + CW'(1));
            default: begin
              row_d = row_q;
              col_d = col_q;
            end
          endcase
        end else begin
          row_d = row_q;
          col_d = col_q;
        end
      end
      GS_IDLE, GS_WIN, GS_LOSE: begin
        if (load_go_s) begin
          state_d = GS_PLAY;
          mine_d  = mine_in;
          flag_d  = {N{1'b0}};
          step_d  = {N{1'b0}};
          row_d   = {RW{1'b0}};
          col_d   = {CW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = GS_IDLE;
    endcase
  end

  always_comb begin
    new_idx_s   = IW'(cell_idx(int'(row_d), int'(col_d), COLS));
    pos_map_d   = POS0 << new_idx_s;
    adj_d       = adj_popcount(mine_q, row_q, col_q);
    win_d       = (state_d == GS_WIN);
    lose_d      = (state_d == GS_LOSE);
    flag_prev_d = flag_req;
    step_prev_d = step_req;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= GS_IDLE;
      mine_q      <= {N{1'b0}};
      flag_q      <= {N{1'b0}};
      step_q      <= {N{1'b0}};
      pos_map_q   <= POS0;
      row_q       <= {RW{1'b0}};
      col_q       <= {CW{1'b0}};
      adj_q       <= 4'd0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      flag_prev_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mine_q      <= mine_d;
      flag_q      <= flag_d;
      step_q      <= step_d;
      pos_map_q   <= pos_map_d;
      row_q       <= row_d;
      col_q       <= col_d;
      adj_q       <= adj_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      flag_prev_q <= flag_prev_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign mine_map   = mine_q;
  assign flag_map   = flag_q;
  assign step_map   = step_q;
  assign pos_map    = pos_map_q;
  assign pos_row    = row_q;
  assign pos_col    = col_q;
  assign adj_count  = adj_q;
  assign game_state = state_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_grid_game_datapath.sv
// Bench for grid_game_datapath: a clamping and a wrapping instance share the
// stimulus and are compared against a cycle-level model of the game rules.
module tb_grid_game_datapath;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int TD   = 4;
  localparam int N    = ROWS * COLS;

  localparam logic [3:0] UP    = 4'b0001;
  localparam logic [3:0] RIGHT = 4'b0010;
  localparam logic [3:0] DOWN  = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b1000;

  typedef logic [269:0] snap_t;

  logic         clk;
  logic         resetn;
  logic         load;
  logic [N-1:0] mine_in;
  logic [3:0]   dir;
  logic         flag_req;
  logic         step_req;

  logic [N-1:0] c_mine, c_flag, c_step, c_pos;
  logic [2:0]   c_row, c_col;
  logic [3:0]   c_adj;
  logic [1:0]   c_gs;
  logic         c_win, c_lose;
  logic [N-1:0] w_mine, w_flag, w_step, w_pos;
  logic [2:0]   w_row, w_col;
  logic [3:0]   w_adj;
  logic [1:0]   w_gs;
  logic         w_win, w_lose;

  int checks   = 0;
  int failures = 0;

  // Reference state, index 0 = clamping board, 1 = wrapping board.
  logic [N-1:0] m_mine[2];
  logic [N-1:0] m_flag[2];
  logic [N-1:0] m_step[2];
  int           m_row[2];
  int           m_col[2];
  int           m_state[2];
  int           m_k[2];
  int           m_adj[2];
  logic         m_fprev;
  logic         m_sprev;
  logic         m_tick;

  grid_game_datapath #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD), .WRAP(0)) u_clamp (
    .clk(clk), .resetn(resetn), .load(load), .mine_in(mine_in), .dir(dir),
    .flag_req(flag_req), .step_req(step_req),
    .mine_map(c_mine), .flag_map(c_flag), .step_map(c_step), .pos_map(c_pos),
    .pos_row(c_row), .pos_col(c_col), .adj_count(c_adj), .game_state(c_gs),
    .win(c_win), .lose(c_lose)
  );

  grid_game_datapath #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD), .WRAP(1)) u_wrap (
    .clk(clk), .resetn(resetn), .load(load), .mine_in(mine_in), .dir(dir),
    .flag_req(flag_req), .step_req(step_req),
    .mine_map(w_mine), .flag_map(w_flag), .step_map(w_step), .pos_map(w_pos),
    .pos_row(w_row), .pos_col(w_col), .adj_count(w_adj), .game_state(w_gs),
    .win(w_win), .lose(w_lose)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_adj(input logic [N-1:0] mines, input int r, input int c);
    int n;
    n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < ROWS) && (c + dc >= 0) && (c + dc < COLS))
          n += int'(mines[6'((r + dr) * COLS + c + dc)]);
      end
    end
    return n;
  endfunction

  function automatic snap_t exp_vec(input int u);
    logic [N-1:0] pm;
    pm = {{(N-1){1'b0}}, 1'b1} << (m_row[u] * COLS + m_col[u]);
    return {2'(m_state[u]), m_mine[u], m_flag[u], m_step[u], pm, 3'(m_row[u]), 3'(m_col[u]),
            4'(m_adj[u]), (m_state[u] == 2), (m_state[u] == 3)};
  endfunction

  function automatic snap_t obs_vec(input int u);
    if (u == 0) return {c_gs, c_mine, c_flag, c_step, c_pos, c_row, c_col, c_adj, c_win, c_lose};
    return {w_gs, w_mine, w_flag, w_step, w_pos, w_row, w_col, w_adj, w_win, w_lose};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_mine[u] = '0; m_flag[u] = '0; m_step[u] = '0;
      m_row[u] = 0; m_col[u] = 0; m_state[u] = 0; m_k[u] = 0; m_adj[u] = 0;
    end
    m_fprev = 1'b0;
    m_sprev = 1'b0;
    m_tick  = 1'b0;
  endtask

  // Advance the model by the cycle whose inputs are currently applied.
  task automatic model_step();
    logic         fr, sr;
    logic [N-1:0] nf, nst;
    logic [5:0]   bi;
    int           ns, dr, dc, nr, nc;
    fr = flag_req && !m_fprev;
    sr = step_req && !m_sprev;
    m_tick = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_adj[u] = ref_adj(m_mine[u], m_row[u], m_col[u]);
      if (m_state[u] != 1) begin
        if (load) begin
          m_mine[u] = mine_in; m_flag[u] = '0; m_step[u] = '0;
          m_row[u] = 0; m_col[u] = 0; m_state[u] = 1; m_k[u] = 1;
        end
      end else begin
        bi = 6'(m_row[u] * COLS + m_col[u]);
        nf = m_flag[u]; nst = m_step[u]; ns = 1;
        if ((m_mine[u] & m_step[u]) != '0) ns = 3;
        else if (m_flag[u] == m_mine[u] && m_mine[u] != '0) ns = 2;
        if (fr) begin
          if (!m_step[u][bi]) nf[bi] = !nf[bi];
        end else if (sr && !m_flag[u][bi]) begin
          nst[bi] = 1'b1;
        end
        if (m_k[u] % TD == 0) begin
          if (u == 0) m_tick = 1'b1;
          dr = 0; dc = 0;
          case (dir)
            UP: dr = -1;
            RIGHT: dc = 1;
            DOWN: dr = 1;
            LEFT: dc = -1;
            default: begin dr = 0; dc = 0; end
          endcase
          nr = m_row[u] + dr;
          nc = m_col[u] + dc;
          if (u == 1) begin
            nr = (nr + ROWS) % ROWS;
            nc = (nc + COLS) % COLS;
          end else begin
            nr = (nr < 0) ? 0 : ((nr > ROWS - 1) ? ROWS - 1 : nr);
            nc = (nc < 0) ? 0 : ((nc > COLS - 1) ? COLS - 1 : nc);
          end
          m_row[u] = nr;
          m_col[u] = nc;
        end
        m_flag[u] = nf; m_step[u] = nst; m_state[u] = ns; m_k[u]++;
      end
    end
    m_fprev = flag_req;
    m_sprev = step_req;
  endtask

  task automatic step_clk();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [N-1:0] mines);
    load = 1'b0; flag_req = 1'b0; step_req = 1'b0; dir = 4'b0000;
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    model_reset();
    mine_in = mines;
    load = 1'b1;
    step_clk();
    load = 1'b0;
  endtask

  task automatic move_one(input logic [3:0] d);
    dir = d;
    for (int n = 0; n < 2 * TD; n++) begin
      step_clk();
      if (m_tick) break;
    end
    dir = 4'b0000;
  endtask

  task automatic test_reset();
    snap_t e, o;
    resetn = 1'b1; load = 1'b0; mine_in = '0; dir = 4'b0000; flag_req = 1'b0; step_req = 1'b0;
    #1 resetn = 1'b0;
    #1;
    model_reset();
    for (int u = 0; u < 2; u++) begin
      e = exp_vec(u); o = obs_vec(u);
      checks++; if (o !== e) begin failures++; $display("FAIL reset_u%0d got=%h exp=%h", u, o, e); end
    end
    checks++; if (c_pos !== 64'd1) begin failures++; $display("FAIL reset_pos_map got=%h exp=1", c_pos); end
    @(posedge clk);
    #3 resetn = 1'b1;
    step_clk();
    checks++; if (c_gs !== 2'd0) begin failures++; $display("FAIL idle_no_load got=%0d exp=0", c_gs); end
  endtask

  task automatic test_load();
    restart(64'h8100);
    checks++; if (c_gs !== 2'd1) begin failures++; $display("FAIL load_state got=%0d exp=1", c_gs); end
    checks++; if (c_mine !== 64'h8100) begin failures++; $display("FAIL load_mine got=%h exp=8100", c_mine); end
    checks++; if (c_pos !== 64'd1) begin failures++; $display("FAIL load_pos got=%h exp=1", c_pos); end
    checks++; if ((c_flag | c_step) !== 64'd0) begin failures++; $display("FAIL load_maps got=%h/%h exp=0", c_flag, c_step); end
  endtask

  task automatic test_clamp_move();
    snap_t e, o;
    restart(64'd0);
    dir = LEFT;
    repeat (3 * TD) step_clk();
    checks++; if ({c_row, c_col} !== 6'd0) begin failures++; $display("FAIL clamp_left got=%0d,%0d exp=0,0", c_row, c_col); end
    e = exp_vec(1); o = obs_vec(1);
    checks++; if (o !== e) begin failures++; $display("FAIL wrap_left got=%h exp=%h", o, e); end
    restart(64'd0);
    dir = RIGHT;
    repeat (3 * TD) step_clk();
    checks++; if (c_col !== 3'd3 || c_pos !== 64'h8) begin failures++; $display("FAIL clamp_right3 got=%0d/%h exp=3/8", c_col, c_pos); end
    checks++; if (w_col !== 3'd3 || w_pos !== 64'h8) begin failures++; $display("FAIL wrap_right3 got=%0d/%h exp=3/8", w_col, w_pos); end
    dir = 4'b0011;
    repeat (2 * TD) step_clk();
    checks++; if ({c_row, c_col} !== 6'd3) begin failures++; $display("FAIL multi_dir got=%0d,%0d exp=0,3", c_row, c_col); end
    dir = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_pm;
    restart(64'd0);
    dir = RIGHT;
    repeat (7 * TD) step_clk();
    checks++; if ({w_row, w_col} !== {3'd0, 3'd7}) begin failures++; $display("FAIL wrap_at_07 got=%0d,%0d exp=0,7", w_row, w_col); end
    repeat (TD) step_clk();
    checks++; if ({w_row, w_col} !== 6'd0 || w_pos !== 64'd1) begin failures++; $display("FAIL wrap_right got=%0d,%0d exp=0,0", w_row, w_col); end
    checks++; if ({c_row, c_col} !== {3'd0, 3'd7}) begin failures++; $display("FAIL clamp_right_edge got=%0d,%0d exp=0,7", c_row, c_col); end
    dir = UP;
    repeat (TD) step_clk();
    exp_pm = 64'd1 << 56;
    checks++; if ({w_row, w_col} !== {3'd7, 3'd0} || w_pos !== exp_pm) begin failures++; $display("FAIL wrap_up got=%0d,%0d exp=7,0", w_row, w_col); end
    checks++; if ({c_row, c_col} !== {3'd0, 3'd7}) begin failures++; $display("FAIL clamp_up_edge got=%0d,%0d exp=0,7", c_row, c_col); end
    dir = 4'b0000;
  endtask

  task automatic test_win();
    restart(64'h102);
    step_clk();
    checks++; if (c_adj !== 4'd2 || w_adj !== 4'd2) begin failures++; $display("FAIL adj_00 got=%0d/%0d exp=2", c_adj, w_adj); end
    move_one(RIGHT);
    flag_req = 1'b1; step_clk(); flag_req = 1'b0; step_clk();
    checks++; if (c_flag !== 64'h2) begin failures++; $display("FAIL flag_cell1 got=%h exp=2", c_flag); end
    move_one(LEFT);
    move_one(DOWN);
    checks++; if ({c_row, c_col} !== {3'd1, 3'd0}) begin failures++; $display("FAIL pos_10 got=%0d,%0d exp=1,0", c_row, c_col); end
    flag_req = 1'b1; step_clk();
    checks++; if (c_flag !== 64'h102 || c_win !== 1'b0) begin failures++; $display("FAIL win_t1 got=%h/%b exp=102/0", c_flag, c_win); end
    flag_req = 1'b0; step_clk();
    checks++; if (c_win !== 1'b1 || c_gs !== 2'd2 || w_win !== 1'b1) begin failures++; $display("FAIL win_t2 got=%b/%0d exp=1/2", c_win, c_gs); end
    flag_req = 1'b1; step_clk(); flag_req = 1'b0; step_clk();
    dir = RIGHT;
    repeat (2 * TD) step_clk();
    dir = 4'b0000;
    checks++; if (c_flag !== 64'h102 || c_col !== 3'd0 || c_gs !== 2'd2) begin failures++; $display("FAIL win_frozen got=%h/%0d/%0d exp=102/0/2", c_flag, c_col, c_gs); end
  endtask

  task automatic test_lose();
    logic [N-1:0] nm;
    restart(64'h101);
    move_one(DOWN);
    flag_req = 1'b1; step_clk(); flag_req = 1'b0; step_clk();
    checks++; if (c_flag !== 64'h100) begin failures++; $display("FAIL flag_cell8 got=%h exp=100", c_flag); end
    step_req = 1'b1; step_clk(); step_req = 1'b0; step_clk();
    checks++; if (c_step !== 64'd0) begin failures++; $display("FAIL step_on_flag got=%h exp=0", c_step); end
    flag_req = 1'b1; step_clk(); flag_req = 1'b0; step_clk();
    checks++; if (c_flag !== 64'd0) begin failures++; $display("FAIL unflag got=%h exp=0", c_flag); end
    step_req = 1'b1; step_clk();
    checks++; if (c_step !== 64'h100 || c_lose !== 1'b0) begin failures++; $display("FAIL lose_t1 got=%h/%b exp=100/0", c_step, c_lose); end
    step_req = 1'b0; step_clk();
    checks++; if (c_lose !== 1'b1 || c_gs !== 2'd3 || w_lose !== 1'b1) begin failures++; $display("FAIL lose_t2 got=%b/%0d exp=1/3", c_lose, c_gs); end
    nm = {$urandom, $urandom};
    mine_in = nm; load = 1'b1; step_clk(); load = 1'b0;
    checks++; if (c_gs !== 2'd1 || c_mine !== nm || (c_flag | c_step) !== 64'd0) begin failures++; $display("FAIL reload got=%0d/%h exp=1/%h", c_gs, c_mine, nm); end
  endtask

  task automatic test_step_hold();
    snap_t e, o;
    restart(64'h100);
    step_req = 1'b1; dir = RIGHT;
    repeat (10) step_clk();
    step_req = 1'b0; dir = 4'b0000;
    step_clk();
    checks++; if (c_step !== 64'd1) begin failures++; $display("FAIL step_hold got=%h exp=1", c_step); end
    e = exp_vec(1); o = obs_vec(1);
    checks++; if (o !== e) begin failures++; $display("FAIL step_hold_wrap got=%h exp=%h", o, e); end
  endtask

  task automatic test_reset_async();
    snap_t e, o;
    restart(64'h8100);
    dir = RIGHT;
    repeat (6) step_clk();
    dir = 4'b0000;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    for (int u = 0; u < 2; u++) begin
      e = exp_vec(u); o = obs_vec(u);
      checks++; if (o !== e) begin failures++; $display("FAIL async_reset_u%0d got=%h exp=%h", u, o, e); end
    end
    #1 resetn = 1'b1;
  endtask

  task automatic test_random();
    snap_t e, o;
    int    r;
    restart({$urandom, $urandom} & {$urandom, $urandom});
    for (int n = 0; n < 600; n++) begin
      load = ($urandom_range(0, 29) == 0);
      if (load) mine_in = {$urandom, $urandom} & {$urandom, $urandom};
      flag_req = ($urandom_range(0, 3) == 0);
      step_req = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 9);
      if (r < 4) dir = 4'b0001 << r;
      else if (r == 4) dir = 4'b0000;
      else if (r == 5) dir = 4'($urandom_range(0, 15));
      step_clk();
      for (int u = 0; u < 2; u++) begin
        e = exp_vec(u); o = obs_vec(u);
        checks++; if (o !== e) begin failures++; $display("FAIL random_c%0d_u%0d got=%h exp=%h", n, u, o, e); end
      end
    end
    load = 1'b0; flag_req = 1'b0; step_req = 1'b0; dir = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_load();
    test_clamp_move();
    test_wrap();
    test_win();
    test_lose();
    test_step_hold();
    test_reset_async();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
